// File: rtl/counter_timer_arbiter.sv
// Purpose : shares one external WIDTH-bit loadable up-counter between two interval
//           requesters; round-robin grant, load TERM-dur, count to TERM, pulse done.
// Latency : req sampled at edge k -> LOAD k+1, COUNT dur+1 cycles, done during cycle k+dur+3.
// Backpr. : a waiting requester simply holds req high; nothing ever preempts a running interval.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req[1:0]          level requests, held until the matching done pulse
//   dur0, dur1        interval length (counts) per requester, sampled at grant
//   Q                 current value of the external counter
//   enb, modo, data   counter controls (modo=1 load data, modo=0 count up)
//   grant[1:0]        one-hot current owner, 0 when idle
//   done[1:0]         one-cycle end-of-interval pulse to the owner
//   busy              high whenever the FSM is not idle
//
// Optional build macro TIMER_ARB_ABORT_EN: the owner dropping req during LOAD or
// COUNT abandons the interval (no done) and passes priority to the other side.
module counter_timer_arbiter #(
    parameter int   WIDTH   = 4,
    parameter logic RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] dur0,
    input  logic [WIDTH-1:0] dur1,
    input  logic [WIDTH-1:0] Q,
    output logic             enb,
    output logic             modo,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic             busy
);

    localparam logic [WIDTH-1:0] TERM = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       done_q,  done_d;
    logic             busy_q,  busy_d;
    logic             enb_q,   enb_d;
    logic             modo_q,  modo_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             prio_q,  prio_d;   // index of the requester that wins a tie

    logic             pick;
    logic [WIDTH-1:0] dur_sel;
    logic             at_term;
`ifdef TIMER_ARB_ABORT_EN
    logic             owner_req;
`endif

    always_comb begin
        // Single requester wins outright; a tie goes to the priority holder.
        pick = prio_q;
        if (req == 2'b01) begin
            pick = 1'b0;
        end else if (req == 2'b10) begin
            pick = 1'b1;
        end
        dur_sel = pick ? dur1 : dur0;
        at_term = (Q == TERM);
`ifdef TIMER_ARB_ABORT_EN
        owner_req = |(req & grant_q);
`endif

        state_d = state_q;
        grant_d = grant_q;
        done_d  = 2'b00;
        enb_d   = 1'b0;
        modo_d  = 1'b0;
        data_d  = data_q;
        prio_d  = prio_q;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    state_d = S_LOAD;
                    grant_d = pick ? 2'b10 : 2'b01;
                    enb_d   = 1'b1;
                    modo_d  = 1'b1;
                    // Loading TERM-dur makes the counter reach TERM after dur increments.
                    data_d  = TERM - dur_sel;
                end
            end
            S_LOAD: begin
                state_d = S_COUNT;
`ifdef TIMER_ARB_ABORT_EN
                if (!owner_req) begin
                    state_d = S_IDLE;
                    grant_d = 2'b00;
                    prio_d  = grant_q[0];
                end
`endif
            end
            S_COUNT: begin
                if (at_term) begin
                    state_d = S_DONE;
                    done_d  = grant_q;
                end
`ifdef TIMER_ARB_ABORT_EN
                if (!owner_req) begin
                    state_d = S_IDLE;
                    grant_d = 2'b00;
                    done_d  = 2'b00;
                    prio_d  = grant_q[0];
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
                // Owner 0 hands priority to 1 and vice versa.
                prio_d  = grant_q[0];
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
            enb_q   <= 1'b0;
            modo_q  <= 1'b0;
            data_q  <= '0;
            prio_q  <= RR_INIT;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            enb_q   <= enb_d;
            modo_q  <= modo_d;
            data_q  <= data_d;
            prio_q  <= prio_d;
        end
    end

    // In COUNT the enable must drop in the very cycle Q hits TERM so the counter
    // parks there instead of wrapping; everywhere else enb is the registered value.
    assign enb   = (state_q == S_COUNT) ? ~at_term : enb_q;
    assign modo  = modo_q;
    assign data  = data_q;
    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_counter_timer_arbiter.sv
module tb_counter_timer_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [3:0] dur0, dur1, Q;
    logic       enb, modo, busy;
    logic [3:0] data;
    logic [1:0] grant, done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    counter_timer_arbiter #(.WIDTH(4), .RR_INIT(1'b0)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .dur0 (dur0),
        .dur1 (dur1),
        .Q    (Q),
        .enb  (enb),
        .modo (modo),
        .data (data),
        .grant(grant),
        .done (done),
        .busy (busy)
    );

    // External 4-bit loadable up-counter the arbiter drives.
    always_ff @(posedge clk) begin
        if (reset)    Q <= 4'd0;
        else if (enb) Q <= modo ? data : Q + 4'd1;
    end

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 2'b00; dur0 = 4'd0; dur1 = 4'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({enb, modo, data, grant, done, busy} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got enb=%b modo=%b data=%0d grant=%b done=%b busy=%b expected all 0",
                     enb, modo, data, grant, done, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got grant=%b busy=%b expected 00/0", grant, busy);
        end
    endtask

    // req=01, dur0=3: data 12, Q 12..15, done at the 6th sample.
    task automatic test_single();
        do_reset();
        dur0 = 4'd3; dur1 = 4'd9; req = 2'b01;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            if (j == 1) begin
                vectors++;
                if (grant !== 2'b01 || enb !== 1'b1 || modo !== 1'b1 || data !== 4'd12 || busy !== 1'b1 || done !== 2'b00) begin
                    miscompares++;
                    $display("FAIL single_load: got grant=%b enb=%b modo=%b data=%0d busy=%b done=%b expected 01/1/1/12/1/00",
                             grant, enb, modo, data, busy, done);
                end
                dur0 = 4'd7;   // must be ignored once granted
            end else if (j <= 5) begin
                vectors++;
                if (Q !== 4'(10 + j) || modo !== 1'b0 || enb !== (j != 5) || done !== 2'b00) begin
                    miscompares++;
                    $display("FAIL single_count%0d: got Q=%0d enb=%b modo=%b done=%b expected Q=%0d enb=%b modo=0 done=00",
                             j, Q, enb, modo, done, 10 + j, (j != 5));
                end
            end else if (j == 6) begin
                vectors++;
                if (done !== 2'b01 || enb !== 1'b0 || Q !== 4'd15 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_done: got done=%b enb=%b Q=%0d busy=%b expected 01/0/15/1", done, enb, Q, busy);
                end
                req = 2'b00;
            end else begin
                vectors++;
                if (done !== 2'b00 || busy !== 1'b0 || grant !== 2'b00 || data !== 4'd12) begin
                    miscompares++;
                    $display("FAIL single_idle: got done=%b busy=%b grant=%b data=%0d expected 00/0/00/12", done, busy, grant, data);
                end
            end
        end
    endtask

    // Both request after reset: 0 first (priority), then 1, then priority back on 0.
    task automatic test_arbitration();
        do_reset();
        dur0 = 4'd2; dur1 = 4'd5; req = 2'b11;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            case (j)
                1: begin
                    vectors++;
                    if (grant !== 2'b01 || data !== 4'd13) begin
                        miscompares++;
                        $display("FAIL arb_grant0: got grant=%b data=%0d expected 01/13", grant, data);
                    end
                end
                5: begin
                    vectors++;
                    if (done !== 2'b01) begin
                        miscompares++;
                        $display("FAIL arb_done0: got done=%b expected 01", done);
                    end
                    req = 2'b10;
                end
                6: begin
                    vectors++;
                    if (grant !== 2'b00 || busy !== 1'b0) begin
                        miscompares++;
                        $display("FAIL arb_gap: got grant=%b busy=%b expected 00/0", grant, busy);
                    end
                end
                7: begin
                    vectors++;
                    if (grant !== 2'b10 || data !== 4'd10) begin
                        miscompares++;
                        $display("FAIL arb_grant1: got grant=%b data=%0d expected 10/10", grant, data);
                    end
                end
                14: begin
                    vectors++;
                    if (done !== 2'b10) begin
                        miscompares++;
                        $display("FAIL arb_done1: got done=%b expected 10", done);
                    end
                    req = 2'b00;
                end
                15: req = 2'b11;
                16: begin
                    vectors++;
                    if (grant !== 2'b01) begin
                        miscompares++;
                        $display("FAIL arb_prio_back0: got grant=%b expected 01", grant);
                    end
                end
                default: ;
            endcase
        end
    endtask

    // dur=0: load 15, single COUNT cycle with enb low, counter stays at 15.
    task automatic test_zero_dur();
        do_reset();
        dur0 = 4'd0; dur1 = 4'd0; req = 2'b01;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            case (j)
                1: begin
                    vectors++;
                    if (data !== 4'd15 || enb !== 1'b1 || modo !== 1'b1) begin
                        miscompares++;
                        $display("FAIL zero_load: got data=%0d enb=%b modo=%b expected 15/1/1", data, enb, modo);
                    end
                end
                2: begin
                    vectors++;
                    if (Q !== 4'd15 || enb !== 1'b0 || modo !== 1'b0 || done !== 2'b00) begin
                        miscompares++;
                        $display("FAIL zero_count: got Q=%0d enb=%b modo=%b done=%b expected 15/0/0/00", Q, enb, modo, done);
                    end
                end
                3: begin
                    vectors++;
                    if (done !== 2'b01) begin
                        miscompares++;
                        $display("FAIL zero_done: got done=%b expected 01", done);
                    end
                    req = 2'b00;
                end
                default: begin
                    vectors++;
                    if (Q !== 4'd15 || busy !== 1'b0 || done !== 2'b00) begin
                        miscompares++;
                        $display("FAIL zero_nowrap: got Q=%0d busy=%b done=%b expected 15/0/00", Q, busy, done);
                    end
                end
            endcase
        end
    endtask

    // Reset mid-COUNT at Q=9: everything clears, no done ever appears.
    task automatic test_reset_mid();
        do_reset();
        dur0 = 4'd9; req = 2'b01;
        for (int j = 1; j <= 18; j++) begin
            @(negedge clk);
            if (j == 5) begin
                vectors++;
                if (Q !== 4'd9 || enb !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rstmid_q9: got Q=%0d enb=%b expected 9/1", Q, enb);
                end
                reset = 1'b1;
                req   = 2'b00;
            end else if (j == 6) begin
                vectors++;
                if ({enb, modo, data, grant, done, busy} !== 11'd0) begin
                    miscompares++;
                    $display("FAIL rstmid_clear: got enb=%b modo=%b data=%0d grant=%b done=%b busy=%b expected all 0",
                             enb, modo, data, grant, done, busy);
                end
                reset = 1'b0;
            end else if (j > 6) begin
                vectors++;
                if (done !== 2'b00 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rstmid_quiet%0d: got done=%b busy=%b expected 00/0", j, done, busy);
                end
            end
        end
    endtask

    // Owner drops req mid-COUNT while requester 1 raises its own.
    task automatic test_drop();
        do_reset();
        dur0 = 4'd4; dur1 = 4'd2; req = 2'b01;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            if (j == 1) begin
                vectors++;
                if (grant !== 2'b01 || data !== 4'd11) begin
                    miscompares++;
                    $display("FAIL drop_load: got grant=%b data=%0d expected 01/11", grant, data);
                end
            end
            if (j == 3) req = 2'b10;
`ifdef TIMER_ARB_ABORT_EN
            if (j == 4) begin
                vectors++;
                if (enb !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 || done !== 2'b00) begin
                    miscompares++;
                    $display("FAIL drop_abort: got enb=%b grant=%b busy=%b done=%b expected 0/00/0/00", enb, grant, busy, done);
                end
            end
            if (j == 5) begin
                vectors++;
                if (grant !== 2'b10 || data !== 4'd13) begin
                    miscompares++;
                    $display("FAIL drop_regrant: got grant=%b data=%0d expected 10/13", grant, data);
                end
            end
`else
            if (j == 4) begin
                vectors++;
                if (enb !== 1'b1 || grant !== 2'b01 || Q !== 4'd13) begin
                    miscompares++;
                    $display("FAIL drop_continue: got enb=%b grant=%b Q=%0d expected 1/01/13", enb, grant, Q);
                end
            end
            if (j == 7) begin
                vectors++;
                if (done !== 2'b01) begin
                    miscompares++;
                    $display("FAIL drop_done: got done=%b expected 01", done);
                end
            end
            if (j == 9) begin
                vectors++;
                if (grant !== 2'b10 || data !== 4'd13) begin
                    miscompares++;
                    $display("FAIL drop_next: got grant=%b data=%0d expected 10/13", grant, data);
                end
            end
`endif
        end
    endtask

    // Both held high, dur=1: a 5-cycle period with alternating owners.
    task automatic test_back_to_back();
        logic [1:0] exp_g, exp_d;
        int p, m;
        do_reset();
        dur0 = 4'd1; dur1 = 4'd1; req = 2'b11;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            p = (j - 1) % 5;
            m = (j - 1) / 5;
            exp_g = (p < 4) ? ((m % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_d = (p == 3) ? exp_g : 2'b00;
            vectors++;
            if (grant !== exp_g || done !== exp_d) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d: got grant=%b done=%b expected %b/%b", j, grant, done, exp_g, exp_d);
            end
        end
        req = 2'b00;
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; dur0 = 4'd0; dur1 = 4'd0;
        test_reset();
        test_single();
        test_arbitration();
        test_zero_dur();
        test_reset_mid();
        test_drop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
